// File: rtl/sd_demuxn.sv
// Narrow-to-wide stream demux: gathers up to `ratio` beats of `width` bits into one
// output word, with c_last closing a word early and a one-word skid held in acc.
module sd_demuxn #(
    parameter int unsigned width = 8,
    parameter int unsigned ratio = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          c_srdy,
    output logic                          c_drdy,
    input  logic [width-1:0]              c_data,
    input  logic                          c_last,
    output logic                          p_srdy,
    input  logic                          p_drdy,
    output logic [width*ratio-1:0]        p_data,
    output logic [$clog2(ratio+1)-1:0]    p_cnt
);
    localparam int unsigned IW = $clog2(ratio);
    localparam int unsigned CW = $clog2(ratio + 1);
    localparam int unsigned DW = width * ratio;

    logic [IW-1:0] idx, idx_nxt;
    logic [DW-1:0] acc, acc_nxt;
    logic [CW-1:0] pend_cnt, pend_cnt_nxt;
    logic          pend, pend_nxt;
    logic          p_srdy_nxt;
    logic [DW-1:0] p_data_nxt;
    logic [CW-1:0] p_cnt_nxt;
    logic          c_xfer, out_free, complete;
    logic [DW-1:0] word;

    // Completed word: accumulated slots below idx, current beat at idx, zeros above.
    always_comb begin
        c_xfer   = c_srdy & c_drdy;
        out_free = ~p_srdy | p_drdy;
        complete = (idx == IW'(ratio - 1)) | c_last;
        word     = '0;
        for (int unsigned i = 0; i < ratio; i++) begin
            if (IW'(i) < idx) begin
                word[i*width +: width] = acc[i*width +: width];
            end else if (IW'(i) == idx) begin
                word[i*width +: width] = c_data;
            end
        end
    end

    always_comb begin
        idx_nxt      = idx;
        acc_nxt      = acc;
        pend_nxt     = pend;
        pend_cnt_nxt = pend_cnt;
        p_srdy_nxt   = p_srdy;
        p_data_nxt   = p_data;
        p_cnt_nxt    = p_cnt;

        if (p_srdy && p_drdy) begin
            p_srdy_nxt = 1'b0;
        end

        if (pend) begin
            // Parked word moves out as soon as the output register frees up.
            if (out_free) begin
                p_srdy_nxt = 1'b1;
                p_data_nxt = acc;
                p_cnt_nxt  = pend_cnt;
                pend_nxt   = 1'b0;
                acc_nxt    = '0;
            end
        end else if (c_xfer) begin
            if (complete) begin
                idx_nxt = '0;
                if (out_free) begin
                    p_srdy_nxt = 1'b1;
                    p_data_nxt = word;
                    p_cnt_nxt  = CW'(idx) + CW'(1);
                    acc_nxt    = '0;
                end else begin
                    acc_nxt      = word;
                    pend_nxt     = 1'b1;
                    pend_cnt_nxt = CW'(idx) + CW'(1);
                end
            end else begin
                for (int unsigned i = 0; i < ratio; i++) begin
                    if (IW'(i) == idx) begin
                        acc_nxt[i*width +: width] = c_data;
                    end
                end
                idx_nxt = idx + IW'(1);
            end
        end
    end

    // c_drdy is a pure register image of ~pend, held low through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            acc      <= '0;
            pend     <= 1'b0;
            pend_cnt <= '0;
            p_srdy   <= 1'b0;
            p_data   <= '0;
            p_cnt    <= '0;
            c_drdy   <= 1'b0;
        end else begin
            idx      <= idx_nxt;
            acc      <= acc_nxt;
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt_nxt;
            p_srdy   <= p_srdy_nxt;
            p_data   <= p_data_nxt;
            p_cnt    <= p_cnt_nxt;
            c_drdy   <= ~pend_nxt;
        end
    end

endmodule

// File: tb/tb_sd_demuxn.sv
// Bench for sd_demuxn: directed scenarios plus a random stream, checked by a
// beat-list reference model feeding an expected-word queue popped by a monitor.
module tb_sd_demuxn;
    localparam int unsigned W  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned CW = $clog2(R + 1);
    localparam int unsigned DW = W * R;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          c_srdy = 1'b0;
    logic          c_drdy;
    logic [W-1:0]  c_data = '0;
    logic          c_last = 1'b0;
    logic          p_srdy;
    logic          p_drdy = 1'b0;
    logic [DW-1:0] p_data;
    logic [CW-1:0] p_cnt;

    word_t        exp_q[$];
    logic [W-1:0] cur_beats[$];
    int           total = 0;
    int           bad = 0;
    int           words_made = 0;
    logic         last_acc;

    sd_demuxn #(.width(W), .ratio(R)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_last(c_last),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_cnt(p_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: collect beats; a word is done at ratio beats or on c_last.
    function automatic void model_beat(input logic [W-1:0] d, input logic last);
        word_t w;
        cur_beats.push_back(d);
        if (last || cur_beats.size() == R) begin
            w.d = '0;
            foreach (cur_beats[i]) w.d[i*W +: W] = cur_beats[i];
            w.c = CW'(cur_beats.size());
            exp_q.push_back(w);
            cur_beats.delete();
            words_made++;
        end
    endfunction

    // Drive one cycle on the falling edge; outputs are registered so the
    // handshake that the next rising edge will see is known right here.
    task automatic drive(input logic rst, input logic srdy, input logic [W-1:0] d,
                         input logic last, input logic pr);
        @(negedge clk);
        reset = rst; c_srdy = srdy; c_data = d; c_last = last; p_drdy = pr;
        last_acc = 1'b0;
        if (rst) begin
            cur_beats.delete();
            exp_q.delete();
        end else if (srdy && c_drdy) begin
            last_acc = 1'b1;
            model_beat(d, last);
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last, input logic pr);
        for (int k = 0; k < 100; k++) begin
            drive(1'b0, 1'b1, d, last, pr);
            if (last_acc) return;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input logic pr);
        drive(1'b0, 1'b0, '0, 1'b0, pr);
    endtask

    // Monitor: pop and compare on every downstream transfer; check holds.
    initial begin : monitor
        logic          prev_hold;
        logic [DW-1:0] prev_data;
        logic [CW-1:0] prev_cnt;
        word_t         w;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_cnt  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (prev_hold) begin
                    check("hold_data", 64'(p_data), 64'(prev_data));
                    check("hold_cnt", 64'(p_cnt), 64'(prev_cnt));
                end
                if (p_srdy && p_drdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(p_data), 64'hDEAD);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_data", 64'(p_data), 64'(w.d));
                        check("word_cnt", 64'(p_cnt), 64'(w.c));
                    end
                end
                prev_hold = p_srdy && !p_drdy;
                prev_data = p_data;
                prev_cnt  = p_cnt;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        int cyc;
        // Reset state
        repeat (3) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("rst_p_srdy", 64'(p_srdy), 64'd0);
        check("rst_p_data", 64'(p_data), 64'd0);
        check("rst_p_cnt", 64'(p_cnt), 64'd0);
        check("rst_c_drdy", 64'(c_drdy), 64'd0);
        idle(1'b1);
        idle(1'b1);
        check("post_rst_c_drdy", 64'(c_drdy), 64'd1);

        // Full word, one-cycle latency
        send_beat(8'h11, 1'b0, 1'b1);
        send_beat(8'h22, 1'b0, 1'b1);
        send_beat(8'h33, 1'b0, 1'b1);
        send_beat(8'h44, 1'b0, 1'b1);
        idle(1'b1);
        check("full_p_srdy", 64'(p_srdy), 64'd1);
        check("full_p_data", 64'(p_data), 64'h44332211);
        check("full_p_cnt", 64'(p_cnt), 64'd4);

        // Partial word, then next word from slot 0
        send_beat(8'hAA, 1'b0, 1'b1);
        send_beat(8'hBB, 1'b1, 1'b1);
        idle(1'b1);
        check("part_p_data", 64'(p_data), 64'h0000BBAA);
        check("part_p_cnt", 64'(p_cnt), 64'd2);
        send_beat(8'hCC, 1'b0, 1'b1);
        send_beat(8'hDD, 1'b0, 1'b1);
        send_beat(8'hEE, 1'b0, 1'b1);
        send_beat(8'hFF, 1'b1, 1'b1);
        idle(1'b1);
        check("after_part_data", 64'(p_data), 64'hFFEEDDCC);
        check("last_on_final_cnt", 64'(p_cnt), 64'd4);

        // Continuous streaming: a beat accepted every cycle
        for (int i = 0; i < 3 * R; i++) begin
            drive(1'b0, 1'b1, W'($urandom), 1'b0, 1'b1);
            check("stream_accept", 64'(last_acc), 64'd1);
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure across two words
        for (int i = 0; i < R; i++) send_beat(W'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < R; i++) send_beat(W'(8'hB0 + i), 1'b0, 1'b0);
        idle(1'b0);
        check("pend_c_drdy", 64'(c_drdy), 64'd0);
        check("pend_p_data", 64'(p_data), 64'hA3A2A1A0);
        repeat (3) idle(1'b0);
        check("pend_c_drdy_held", 64'(c_drdy), 64'd0);
        idle(1'b1);
        idle(1'b1);
        check("pend_second_data", 64'(p_data), 64'hB3B2B1B0);
        check("pend_released_c_drdy", 64'(c_drdy), 64'd1);
        idle(1'b1);

        // Reset mid-word
        send_beat(8'h77, 1'b0, 1'b1);
        send_beat(8'h78, 1'b0, 1'b1);
        repeat (2) drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("midrst_c_drdy", 64'(c_drdy), 64'd0);
        check("midrst_p_srdy", 64'(p_srdy), 64'd0);
        idle(1'b1);
        for (int i = 1; i <= R; i++) send_beat(W'(i), 1'b0, 1'b1);
        idle(1'b1);
        check("midrst_next_word", 64'(p_data), 64'h04030201);

        // Reset with a parked word
        for (int i = 0; i < 2 * R; i++) send_beat(W'(8'hC0 + i), 1'b0, 1'b0);
        idle(1'b0);
        check("pendrst_pend", 64'(c_drdy), 64'd0);
        repeat (2) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("pendrst_p_data", 64'(p_data), 64'd0);
        check("pendrst_p_cnt", 64'(p_cnt), 64'd0);
        check("pendrst_c_drdy", 64'(c_drdy), 64'd0);
        idle(1'b1);
        send_beat(8'h5A, 1'b1, 1'b1);
        idle(1'b1);
        check("pendrst_next_word", 64'(p_data), 64'h0000005A);
        check("pendrst_next_cnt", 64'(p_cnt), 64'd1);
        idle(1'b1);

        // Random traffic
        words_made = 0;
        cyc = 0;
        while (words_made < 1000 && cyc < 40000) begin
            drive(1'b0, ($urandom_range(0, 9) < 7), W'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6));
            cyc++;
        end
        check("random_word_count", 64'(words_made >= 1000), 64'd1);
        send_beat(8'hE5, 1'b1, 1'b1);

        // Drain
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd_demuxn.md
SD_DEMUXN -- requirements
Module: sd_demuxn

Interface
REQ-001 SHALL have parameter width, default 8, meaning the narrow input beat width in bits.
REQ-002 SHALL have parameter ratio, default 4, meaning beats per full output word; legal range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port c_srdy  input  1  upstream beat valid.
REQ-006 SHALL have port c_drdy  output  1  this block accepts the beat.
REQ-007 SHALL have port c_data  input  width  narrow beat data.
REQ-008 SHALL have port c_last  input  1  beat closes the current word early (partial word).
REQ-009 SHALL have port p_srdy  output  1  assembled word valid.
REQ-010 SHALL have port p_drdy  input  1  downstream accepts the word.
REQ-011 SHALL have port p_data  output  width*ratio  assembled word.
REQ-012 SHALL have port p_cnt  output  $clog2(ratio+1)  number of valid beats in p_data, 1..ratio.

Function
REQ-013 SHALL transfer a beat when c_srdy & c_drdy are both high at a rising clk edge; same rule downstream with p_srdy & p_drdy.
REQ-014 SHALL place beat index i (0 = first beat of the word) in p_data bits [i*width +: width].
REQ-015 SHALL keep a beat index idx (0..ratio-1) and an assembly register acc; each accepted non-completing beat writes acc slot idx and increments idx.
REQ-016 SHALL treat an accepted beat as completing when idx==ratio-1 or c_last==1.
REQ-017 SHALL, on a completing beat, reset idx to 0 and form word = acc slots 0..idx-1 plus current beat in slot idx, unused slots above idx forced to zero, count = idx+1.
REQ-018 SHALL, when the output register is free at that edge (p_srdy==0 or p_drdy==1), load p_data/p_cnt with the word and set p_srdy=1 on the same edge (one-cycle latency from completing beat to p_srdy).
REQ-019 SHALL, when the output register is not free, hold the word in acc, set pend=1; while pend==1 c_drdy SHALL be 0.
REQ-020 SHALL, when pend==1 and the output register becomes free, load the word from acc into p_data/p_cnt, keep p_srdy=1, clear pend and clear acc.
REQ-021 SHALL clear p_srdy on a downstream transfer unless a new word is loaded on the same edge.
REQ-022 SHALL drive c_drdy = ~pend, registered state only; no combinational path from p_drdy, c_srdy, c_last or c_data to c_drdy.
REQ-023 SHALL hold p_data and p_cnt stable while p_srdy==1 and p_drdy==0.
REQ-024 SHALL sustain one beat per cycle with p_drdy held high (no bubbles at word boundaries).
REQ-025 SHALL treat c_last on beat idx==ratio-1 identically to a normal full word (p_cnt=ratio).
REQ-026 SHALL ignore c_data and c_last when no input transfer occurs.

Reset
REQ-027 SHALL, while reset==1 at a clock edge, set p_srdy=0, p_data=0, p_cnt=0, idx=0, pend=0, acc=0.
REQ-028 SHALL drive c_drdy=0 while reset is high, and 1 on the first cycle after reset deasserts.
REQ-029 SHALL discard any partial word or pending word when reset asserts mid-operation; no output produced for it after reset.

Verification
REQ-030 SHALL (width=8, ratio=4) send beats 0x11,0x22,0x33,0x44 with p_drdy=1 -> p_data=0x44332211, p_cnt=4, p_srdy high one cycle after the 4th beat.
REQ-031 SHALL send 0xAA,0xBB with c_last on 0xBB -> p_data=0x0000BBAA, p_cnt=2; next word starts at slot 0.
REQ-032 SHALL hold p_drdy=0 across two full words -> first word held stable, second completing beat sets pend, c_drdy=0 until p_drdy rises; both words delivered in order, no loss.
REQ-033 SHALL stream 1000 random words (random c_last, random srdy/drdy patterns as in existing sequence benches) -> scoreboard matches every word and count, zero mismatches.
REQ-034 SHALL assert reset after 2 beats of a word and with pend=1 -> all outputs zero, c_drdy=0 during reset; post-reset first word assembles from slot 0 with no stale data.
REQ-035 SHALL stream continuous beats with p_drdy=1 -> one word every ratio cycles, c_drdy never deasserts.
